// File: rtl/frame_writer_rgb888.sv
// Frame-buffer write side: queues processed RGB888 pixels in a small FIFO
// and writes them in raster order through a shared single-port SRAM whenever
// the port is granted. It signals end-of-frame and flags dropped pixels.
module frame_writer_rgb888 #(
  parameter int DATA_W     = 24,
  parameter int ADDR_W     = 17,
  parameter int WIDTH      = 480,
  parameter int HEIGHT     = 272,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int AF_MARGIN  = 2
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iEn,
  input  logic              iValid,
  input  logic [DATA_W-1:0] iPixel,
  output logic              oBusy,
  input  logic              iGrant,
  output logic              oCs,
  output logic              oWe,
  output logic [ADDR_W-1:0] oAddr,
  output logic [DATA_W-1:0] oData,
  output logic              oFrameDone,
  output logic              oOverflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int X_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int Y_W   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  AF_C    = CNT_W'(AF_MARGIN);
  localparam logic [X_W-1:0]    X_LAST  = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0]    Y_LAST  = Y_W'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [ADDR_W-1:0] addr;

  logic full;
  logic pop;
  logic push;
  logic drop;

  // A full FIFO still accepts a pixel when the head leaves in the same cycle.
  assign full = (count == DEPTH_C);
  assign pop  = iEn && iGrant && (count != '0) && (state == S_RUN);
  assign push = iEn && iValid && (!full || pop);
  assign drop = iEn && iValid && full && !pop;

  // Busy depends on the registered occupancy only, so upstream sees no
  // combinational path from this cycle's inputs.
  assign oBusy = ((DEPTH_C - count) <= AF_C);

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge iClk) begin
    if (push) begin
      mem[wr_ptr] <= iPixel;
    end
  end

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap freely.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Frame sequencer: raster address walk, registered SRAM strobes and flags.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state      <= S_IDLE;
      x          <= '0;
      y          <= '0;
      addr       <= BASE_C;
      oCs        <= 1'b0;
      oWe        <= 1'b0;
      oAddr      <= '0;
      oData      <= '0;
      oFrameDone <= 1'b0;
      oOverflow  <= 1'b0;
    end else begin
      oCs        <= 1'b0;
      oWe        <= 1'b0;
      oFrameDone <= 1'b0;
      if (drop) begin
        oOverflow <= 1'b1;
      end
      if (iEn) begin
        case (state)
          S_IDLE: begin
            state <= S_RUN;
          end
          S_RUN: begin
            if (pop) begin
              oCs   <= 1'b1;
              oWe   <= 1'b1;
              oAddr <= addr;
              oData <= mem[rd_ptr];
              if (x == X_LAST) begin
                x <= '0;
                if (y == Y_LAST) begin
                  // Last pixel of the frame: rewind for the next frame.
                  y     <= '0;
                  addr  <= BASE_C;
                  state <= S_DONE;
                end else begin
                  y    <= y + 1'b1;
                  addr <= addr + 1'b1;
                end
              end else begin
                x    <= x + 1'b1;
                addr <= addr + 1'b1;
              end
            end
          end
          S_DONE: begin
            oFrameDone <= 1'b1;
            state      <= S_RUN;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_writer_rgb888.sv
// Scenario bench for frame_writer_rgb888: two instances (a small 4x3 frame
// at address 100 and a 2x2 frame straddling the top of the address space).
module tb_frame_writer_rgb888;

  typedef struct {
    logic [16:0] addr;
    logic [23:0] data;
    int          cyc;
  } wr_t;

  logic clk;
  int   cyc;
  int   checks;
  int   errors;
  int   we_bad;

  logic        rst_a, en_a, valid_a, grant_a;
  logic [23:0] pixel_a;
  logic        busy_a, cs_a, we_a, fd_a, ovf_a;
  logic [16:0] addr_a;
  logic [23:0] data_a;

  logic        rst_b, en_b, valid_b, grant_b;
  logic [23:0] pixel_b;
  logic        busy_b, cs_b, we_b, fd_b, ovf_b;
  logic [16:0] addr_b;
  logic [23:0] data_b;

  wr_t exp_a[$];
  wr_t obs_a[$];
  wr_t exp_b[$];
  wr_t obs_b[$];
  int  fd_a_q[$];
  int  fd_b_q[$];
  wr_t mon_a;
  wr_t mon_b;

  frame_writer_rgb888 #(
    .DATA_W(24), .ADDR_W(17), .WIDTH(4), .HEIGHT(3), .BASE_ADDR(100),
    .FIFO_DEPTH(4), .AF_MARGIN(2)
  ) dut_a (
    .iClk(clk), .iRst(rst_a), .iEn(en_a), .iValid(valid_a), .iPixel(pixel_a),
    .oBusy(busy_a), .iGrant(grant_a), .oCs(cs_a), .oWe(we_a), .oAddr(addr_a),
    .oData(data_a), .oFrameDone(fd_a), .oOverflow(ovf_a)
  );

  frame_writer_rgb888 #(
    .DATA_W(24), .ADDR_W(17), .WIDTH(2), .HEIGHT(2), .BASE_ADDR(131070),
    .FIFO_DEPTH(4), .AF_MARGIN(2)
  ) dut_b (
    .iClk(clk), .iRst(rst_b), .iEn(en_b), .iValid(valid_b), .iPixel(pixel_b),
    .oBusy(busy_b), .iGrant(grant_b), .oCs(cs_b), .oWe(we_b), .oAddr(addr_b),
    .oData(data_b), .oFrameDone(fd_b), .oOverflow(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observe SRAM writes and frame-done pulses away from the active edge.
  always @(negedge clk) begin
    if (cs_a === 1'b1) begin
      mon_a.addr = addr_a; mon_a.data = data_a; mon_a.cyc = cyc;
      obs_a.push_back(mon_a);
    end
    if (cs_b === 1'b1) begin
      mon_b.addr = addr_b; mon_b.data = data_b; mon_b.cyc = cyc;
      obs_b.push_back(mon_b);
    end
    if (fd_a === 1'b1) fd_a_q.push_back(cyc);
    if (fd_b === 1'b1) fd_b_q.push_back(cyc);
    if (cs_a !== we_a || cs_b !== we_b) we_bad = we_bad + 1;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp_a(input int a, input int d);
    wr_t e;
    e.addr = 17'(a); e.data = 24'(d); e.cyc = 0;
    exp_a.push_back(e);
  endtask

  task automatic push_exp_b(input int a, input int d);
    wr_t e;
    e.addr = 17'(a); e.data = 24'(d); e.cyc = 0;
    exp_b.push_back(e);
  endtask

  task automatic wait_a(input int n, input int budget);
    int t = 0;
    while (obs_a.size() < n && t < budget) begin
      cycle();
      t++;
    end
  endtask

  task automatic wait_b(input int n, input int budget);
    int t = 0;
    while (obs_b.size() < n && t < budget) begin
      cycle();
      t++;
    end
  endtask

  task automatic do_reset_a();
    rst_a = 1'b1; en_a = 1'b0; valid_a = 1'b0; grant_a = 1'b0; pixel_a = '0;
    cycle();
    cycle();
    rst_a = 1'b0;
    exp_a.delete(); obs_a.delete(); fd_a_q.delete();
  endtask

  task automatic test_reset();
    rst_a = 1'b1; en_a = 1'b0; valid_a = 1'b0; grant_a = 1'b0; pixel_a = '0;
    rst_b = 1'b1; en_b = 1'b0; valid_b = 1'b0; grant_b = 1'b0; pixel_b = '0;
    repeat (3) cycle();
    checks++; if (cs_a !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b expected 0", cs_a); end
    checks++; if (we_a !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", we_a); end
    checks++; if (addr_a !== 17'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", addr_a); end
    checks++; if (data_a !== 24'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", data_a); end
    checks++; if (fd_a !== 1'b0) begin errors++; $display("FAIL reset_framedone: got %b expected 0", fd_a); end
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", ovf_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    rst_a = 1'b0;
    exp_a.delete(); obs_a.delete(); fd_a_q.delete();
  endtask

  task automatic test_frame();
    int n;
    int w_last;
    wr_t e;
    wr_t o;
    do_reset_a();
    en_a = 1'b1; grant_a = 1'b1;
    w_last = -1;
    for (int i = 1; i <= 13; i++) begin
      valid_a = 1'b1; pixel_a = 24'(i);
      push_exp_a(100 + ((i - 1) % 12), i);
      cycle();
      valid_a = 1'b0;
      cycle();
      cycle();
    end
    n = exp_a.size();
    wait_a(n, 100);
    repeat (4) cycle();
    checks++; if (obs_a.size() != n) begin errors++; $display("FAIL frame_write_count: got %0d expected %0d", obs_a.size(), n); end
    for (int k = 0; k < n; k++) begin
      e = exp_a.pop_front();
      if (obs_a.size() > 0) begin
        o = obs_a.pop_front();
        if (k == 11) w_last = o.cyc;
        checks++;
        if (o.addr !== e.addr || o.data !== e.data) begin
          errors++; $display("FAIL frame_write[%0d]: got addr %0d data %h expected addr %0d data %h", k, o.addr, o.data, e.addr, e.data);
        end
      end
    end
    checks++; if (fd_a_q.size() != 1) begin errors++; $display("FAIL frame_done_count: got %0d expected 1", fd_a_q.size()); end
    if (fd_a_q.size() > 0) begin
      checks++; if (fd_a_q[0] != w_last + 1) begin errors++; $display("FAIL frame_done_cycle: got %0d expected %0d", fd_a_q[0], w_last + 1); end
    end
    checks++; if (we_bad != 0) begin errors++; $display("FAIL we_equals_cs: got %0d mismatching cycles expected 0", we_bad); end
  endtask

  task automatic test_backpressure();
    int cnt;
    int n;
    wr_t e;
    wr_t o;
    do_reset_a();
    en_a = 1'b1; grant_a = 1'b0;
    for (int k = 0; k < 6; k++) begin
      valid_a = 1'b1; pixel_a = 24'(16 + k);
      if (k < 4) push_exp_a(100 + k, 16 + k);
      cycle();
      cnt = (k + 1 > 4) ? 4 : k + 1;
      checks++; if (busy_a !== ((4 - cnt) <= 2)) begin errors++; $display("FAIL bp_busy[%0d]: got %b expected %b", k, busy_a, ((4 - cnt) <= 2)); end
      checks++; if (ovf_a !== (k >= 4)) begin errors++; $display("FAIL bp_overflow[%0d]: got %b expected %b", k, ovf_a, (k >= 4)); end
    end
    valid_a = 1'b0;
    cycle();
    checks++; if (obs_a.size() != 0) begin errors++; $display("FAIL bp_no_write_without_grant: got %0d writes expected 0", obs_a.size()); end
    grant_a = 1'b1;
    n = exp_a.size();
    wait_a(n, 50);
    repeat (4) cycle();
    checks++; if (obs_a.size() != n) begin errors++; $display("FAIL bp_drain_count: got %0d expected %0d", obs_a.size(), n); end
    for (int k = 0; k < n; k++) begin
      e = exp_a.pop_front();
      if (obs_a.size() > 0) begin
        o = obs_a.pop_front();
        checks++;
        if (o.addr !== e.addr || o.data !== e.data) begin
          errors++; $display("FAIL bp_drain[%0d]: got addr %0d data %h expected addr %0d data %h", k, o.addr, o.data, e.addr, e.data);
        end
      end
    end
    checks++; if (ovf_a !== 1'b1) begin errors++; $display("FAIL bp_overflow_sticky: got %b expected 1", ovf_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL bp_busy_after_drain: got %b expected 0", busy_a); end
  endtask

  task automatic test_full_push();
    int n;
    wr_t e;
    wr_t o;
    do_reset_a();
    en_a = 1'b1; grant_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      valid_a = 1'b1; pixel_a = 24'(32 + k);
      push_exp_a(100 + k, 32 + k);
      cycle();
    end
    grant_a = 1'b1; valid_a = 1'b1; pixel_a = 24'h24;
    push_exp_a(104, 36);
    cycle();
    valid_a = 1'b0;
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL full_push_overflow: got %b expected 0", ovf_a); end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL full_push_busy: got %b expected 1", busy_a); end
    n = exp_a.size();
    wait_a(n, 50);
    repeat (4) cycle();
    checks++; if (obs_a.size() != n) begin errors++; $display("FAIL full_push_count: got %0d expected %0d", obs_a.size(), n); end
    for (int k = 0; k < n; k++) begin
      e = exp_a.pop_front();
      if (obs_a.size() > 0) begin
        o = obs_a.pop_front();
        checks++;
        if (o.addr !== e.addr || o.data !== e.data) begin
          errors++; $display("FAIL full_push_write[%0d]: got addr %0d data %h expected addr %0d data %h", k, o.addr, o.data, e.addr, e.data);
        end
      end
    end
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL full_push_overflow_end: got %b expected 0", ovf_a); end
  endtask

  task automatic test_reset_midframe();
    int n;
    wr_t e;
    wr_t o;
    do_reset_a();
    en_a = 1'b1; grant_a = 1'b1;
    for (int k = 0; k < 5; k++) begin
      valid_a = 1'b1; pixel_a = 24'(48 + k);
      push_exp_a(100 + k, 48 + k);
      cycle();
    end
    valid_a = 1'b0;
    n = exp_a.size();
    wait_a(n, 50);
    repeat (2) cycle();
    checks++; if (obs_a.size() != n) begin errors++; $display("FAIL rst_pre_count: got %0d expected %0d", obs_a.size(), n); end
    for (int k = 0; k < n; k++) begin
      e = exp_a.pop_front();
      if (obs_a.size() > 0) begin
        o = obs_a.pop_front();
        checks++;
        if (o.addr !== e.addr || o.data !== e.data) begin
          errors++; $display("FAIL rst_pre_write[%0d]: got addr %0d data %h expected addr %0d data %h", k, o.addr, o.data, e.addr, e.data);
        end
      end
    end
    grant_a = 1'b0;
    for (int k = 0; k < 2; k++) begin
      valid_a = 1'b1; pixel_a = 24'(53 + k);
      cycle();
    end
    valid_a = 1'b0;
    rst_a = 1'b1;
    cycle();
    rst_a = 1'b0;
    checks++; if ({cs_a, we_a, fd_a, ovf_a} !== 4'b0000) begin errors++; $display("FAIL rst_mid_flags: got %b expected 0000", {cs_a, we_a, fd_a, ovf_a}); end
    checks++; if (addr_a !== 17'd0) begin errors++; $display("FAIL rst_mid_addr: got %0d expected 0", addr_a); end
    checks++; if (data_a !== 24'd0) begin errors++; $display("FAIL rst_mid_data: got %h expected 0", data_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy_a); end
    grant_a = 1'b1; valid_a = 1'b1; pixel_a = 24'h37;
    push_exp_a(100, 55);
    cycle();
    valid_a = 1'b0;
    wait_a(1, 50);
    repeat (4) cycle();
    checks++; if (obs_a.size() != 1) begin errors++; $display("FAIL rst_post_count: got %0d expected 1", obs_a.size()); end
    e = exp_a.pop_front();
    if (obs_a.size() > 0) begin
      o = obs_a.pop_front();
      checks++;
      if (o.addr !== e.addr || o.data !== e.data) begin
        errors++; $display("FAIL rst_post_write: got addr %0d data %h expected addr %0d data %h", o.addr, o.data, e.addr, e.data);
      end
    end
  endtask

  task automatic test_enable_hold();
    int n;
    wr_t e;
    wr_t o;
    do_reset_a();
    en_a = 1'b1; grant_a = 1'b1;
    for (int k = 0; k < 2; k++) begin
      valid_a = 1'b1; pixel_a = 24'(64 + k);
      push_exp_a(100 + k, 64 + k);
      cycle();
    end
    valid_a = 1'b0;
    wait_a(2, 50);
    repeat (2) cycle();
    grant_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      valid_a = 1'b1; pixel_a = 24'(66 + k);
      push_exp_a(102 + k, 66 + k);
      cycle();
    end
    valid_a = 1'b0;
    cycle();
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL en_busy_before: got %b expected 1", busy_a); end
    en_a = 1'b0; grant_a = 1'b1; valid_a = 1'b1; pixel_a = 24'hBAD;
    for (int k = 0; k < 8; k++) begin
      cycle();
      checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL en_hold_busy[%0d]: got %b expected 1", k, busy_a); end
    end
    valid_a = 1'b0;
    checks++; if (obs_a.size() != 2) begin errors++; $display("FAIL en_hold_no_write: got %0d writes expected 2", obs_a.size()); end
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL en_hold_overflow: got %b expected 0", ovf_a); end
    en_a = 1'b1;
    n = exp_a.size();
    wait_a(n, 50);
    repeat (4) cycle();
    checks++; if (obs_a.size() != n) begin errors++; $display("FAIL en_resume_count: got %0d expected %0d", obs_a.size(), n); end
    for (int k = 0; k < n; k++) begin
      e = exp_a.pop_front();
      if (obs_a.size() > 0) begin
        o = obs_a.pop_front();
        checks++;
        if (o.addr !== e.addr || o.data !== e.data) begin
          errors++; $display("FAIL en_resume_write[%0d]: got addr %0d data %h expected addr %0d data %h", k, o.addr, o.data, e.addr, e.data);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int n;
    int w_last;
    wr_t e;
    wr_t o;
    int addrs [6];
    addrs = '{131070, 131071, 0, 1, 131070, 131071};
    rst_b = 1'b1;
    cycle();
    cycle();
    rst_b = 1'b0;
    exp_b.delete(); obs_b.delete(); fd_b_q.delete();
    en_b = 1'b1; grant_b = 1'b1;
    w_last = -1;
    for (int k = 0; k < 6; k++) begin
      valid_b = 1'b1; pixel_b = 24'(80 + k);
      push_exp_b(addrs[k], 80 + k);
      cycle();
      valid_b = 1'b0;
      cycle();
      cycle();
    end
    n = exp_b.size();
    wait_b(n, 50);
    repeat (4) cycle();
    checks++; if (obs_b.size() != n) begin errors++; $display("FAIL wrap_count: got %0d expected %0d", obs_b.size(), n); end
    for (int k = 0; k < n; k++) begin
      e = exp_b.pop_front();
      if (obs_b.size() > 0) begin
        o = obs_b.pop_front();
        if (k == 3) w_last = o.cyc;
        checks++;
        if (o.addr !== e.addr || o.data !== e.data) begin
          errors++; $display("FAIL wrap_write[%0d]: got addr %0d data %h expected addr %0d data %h", k, o.addr, o.data, e.addr, e.data);
        end
      end
    end
    checks++; if (fd_b_q.size() != 1) begin errors++; $display("FAIL wrap_done_count: got %0d expected 1", fd_b_q.size()); end
    if (fd_b_q.size() > 0) begin
      checks++; if (fd_b_q[0] != w_last + 1) begin errors++; $display("FAIL wrap_done_cycle: got %0d expected %0d", fd_b_q[0], w_last + 1); end
    end
    checks++; if (we_bad != 0) begin errors++; $display("FAIL wrap_we_equals_cs: got %0d mismatching cycles expected 0", we_bad); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    we_bad = 0;
    test_reset();
    test_frame();
    test_backpressure();
    test_full_push();
    test_reset_midframe();
    test_enable_hold();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_writer_rgb888.md
Name: frame_writer_rgb888

Overview:
Write-side counterpart of the 3x3 window reader. It accepts one processed RGB888 pixel per valid strobe from the filter datapath and writes it, in raster order, into a single-port sync SRAM/BRAM frame buffer. It buffers pixels in a small FIFO and back-pressures upstream through a busy output. It writes to the port only in cycles where the shared port is granted, and it flags end-of-frame.

Parameters:
DATA_W, 24, pixel width (RGB888)
ADDR_W, 17, SRAM address width
WIDTH, 480, frame width in pixels
HEIGHT, 272, frame height in pixels
BASE_ADDR, 0, SRAM address of pixel (0,0)
FIFO_DEPTH, 4, input FIFO entries (power of 2, >=2)
AF_MARGIN, 2, oBusy asserted when free entries <= AF_MARGIN

Ports:
iClk  in  1  clock, all logic on rising edge
iRst  in  1  synchronous reset, active-high
iEn  in  1  global enable; low = hold everything
iValid  in  1  pixel strobe from upstream
iPixel  in  DATA_W  pixel data, sampled when iValid
oBusy  out  1  back-pressure to upstream iBusy
iGrant  in  1  shared SRAM port available for write this cycle
oCs  out  1  SRAM chip select (registered)
oWe  out  1  SRAM write enable (registered, equals oCs)
oAddr  out  ADDR_W  SRAM write address (registered)
oData  out  DATA_W  SRAM write data (registered)
oFrameDone  out  1  one-cycle pulse after last pixel of a frame is written
oOverflow  out  1  sticky: pixel dropped because FIFO was full

Behaviour:
- Reset (iRst=1 at clock edge):
  - oCs, oWe, oAddr, oData, oFrameDone, oOverflow all 0.
  - FIFO emptied (count=0), x=y=0, address register=BASE_ADDR, state=S_IDLE.
  - Reset mid-frame discards FIFO contents and restarts at (0,0). There is no partial-write recovery.
- Push: occurs when iEn && iValid && (count<FIFO_DEPTH || pop this cycle).
  - If iEn && iValid && count==FIFO_DEPTH && no pop: pixel dropped, oOverflow<=1 until reset.
  - iValid with iEn=0 is ignored and is not an overflow.
- Pop: occurs when iEn && iGrant && count>0 && state==S_RUN.
  - A pop registers oCs=oWe=1, oAddr=current address, oData=FIFO head, all valid in the next cycle.
  - In every cycle without a pop, oCs=oWe=0; oAddr/oData hold their last values.
- Simultaneous push and pop: count unchanged, order preserved.
- Latency: pixel presented at edge t is written to the FIFO at t. Earliest pop is at t+1, so oCs is high during cycle t+1..t+2. There is no FIFO bypass.
- oBusy = (FIFO_DEPTH - count) <= AF_MARGIN. It is derived only from the registered count, with no combinational path from inputs. It is 0 after reset.
- Address generation:
  - Incremental, no multiplier: each pop increments x and the address.
  - At x==WIDTH-1: x<=0, y<=y+1, address continues linearly.
  - At last pixel (x==WIDTH-1, y==HEIGHT-1): x,y<=0, address<=BASE_ADDR, state<=S_DONE.
  - Address arithmetic is modulo 2^ADDR_W.
- State machine:
  - S_IDLE: no pops. Goes to S_RUN when iEn=1. Pushes are allowed.
  - S_RUN: pops as above.
  - S_DONE: oFrameDone<=1 for exactly one cycle (next cycle), no pop, pushes allowed. Returns to S_RUN unconditionally if iEn=1; holds if iEn=0.
  - The frame counter wraps; the next frame starts at BASE_ADDR with no software action.
- iEn=0: state, x, y, address, FIFO, and oOverflow all hold. oCs=oWe=0 and oFrameDone=0 in the following cycle.
- iGrant=0: pop stalls, FIFO fills, oBusy throttles upstream.

Test Plan:
1. WIDTH=4, HEIGHT=3, BASE_ADDR=100, iGrant=1, 12 pixels 0x000001..0x00000C with iValid every 3 cycles -> 12 single-cycle writes at addresses 100..111 with matching oData; oFrameDone pulses exactly once, the cycle after the write to 111. A 13th pixel is written to 100.
2. FIFO_DEPTH=4, AF_MARGIN=2, iGrant=0, iValid held high 6 cycles -> oBusy=1 once count=2. Pushes 5 and 6 are dropped and oOverflow=1 stays high. Raising iGrant drains exactly 4 writes in input order.
3. FIFO full (count=4), iGrant=1, and iValid=1 in the same cycle -> push accepted, count stays 4, oOverflow stays 0, no data lost across the next 4 writes.
4. After 5 writes of a WIDTH=4 frame, assert iRst for one cycle with 2 pixels queued -> all outputs 0 the following cycle, queued pixels discarded, next write goes to BASE_ADDR.
5. iEn=0 for 8 cycles mid-row with 3 pixels queued -> no oCs, oBusy unchanged, FIFO retained. After iEn=1, writes resume at the next sequential address in order.
6. WIDTH=2, HEIGHT=2, BASE_ADDR=2^17-2 -> writes to 131070, 131071, 0, 1. oFrameDone follows the write to 1, and the next frame restarts at 131070.
